// File: rtl/sample_streamer.sv
// rtl/sample_streamer.sv - FIFO-backed sample producer streaming bursts to the tracker over valid/ready
module sample_streamer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] c,
    output logic             c_valid,
    input  logic             c_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_count
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop;
    logic             push;

    // Extra pointer MSB distinguishes a full buffer from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign c_valid = (state == S_RUN) && !empty;
    assign pop     = c_valid && c_ready;
    assign push    = wr_en && (!full || pop);
    assign c       = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign busy    = (state == S_RUN);
    assign done    = (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            sent_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_RUN;
                        sent_count <= '0;
                    end
                end
                S_RUN: begin
                    if (pop) sent_count <= sent_count + 1'b1;
                    // Abort wins over burst completion; an incoming write keeps the burst alive.
                    if (stop) state <= S_IDLE;
                    else if (empty && !push) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_streamer.sv
// tb/tb_sample_streamer.sv - queue-model bench for sample_streamer with directed bursts
module tb_sample_streamer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        full, empty, overflow;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] c;
    logic        c_valid;
    logic        c_ready = 1'b0;
    logic        busy, done;
    logic [15:0] sent_count;

    int n_tests = 0;
    int n_fail  = 0;

    sample_streamer #(.WIDTH(32), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .overflow(overflow),
        .start(start), .stop(stop), .c(c), .c_valid(c_valid), .c_ready(c_ready),
        .busy(busy), .done(done), .sent_count(sent_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue of samples plus a phase (0 idle, 1 streaming, 2 finishing)
    logic [31:0] mq[$];
    int          m_phase;
    logic [15:0] m_sent;
    logic        m_ovf;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_phase = 0;
            m_sent  = 0;
            m_ovf   = 0;
        end else begin
            bit tx, was_full, was_empty, accept;
            tx        = (m_phase == 1) && (mq.size() > 0) && c_ready;
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            accept    = wr_en && (!was_full || tx);
            if (wr_en && was_full && !tx) m_ovf = 1;
            case (m_phase)
                0: if (start) begin m_phase = 1; m_sent = 0; end
                1: if (stop) m_phase = 0; else if (was_empty && !accept) m_phase = 2;
                default: m_phase = 0;
            endcase
            if (tx) begin void'(mq.pop_front()); m_sent = m_sent + 16'd1; end
            if (accept) mq.push_back(wr_data);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Observed DUT traffic, compared later against literal sequences
    logic [31:0] got[$];
    int          done_pulses;

    always @(negedge clk) begin
        logic [31:0] exp_c;
        exp_c = (mq.size() > 0) ? mq[0] : 32'd0;
        chk("c", c, exp_c);
        chk("c_valid", c_valid, (m_phase == 1) && (mq.size() > 0));
        chk("full", full, mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("overflow", overflow, m_ovf);
        chk("busy", busy, m_phase == 1);
        chk("done", done, m_phase == 2);
        chk("sent_count", sent_count, m_sent);
        if (c_valid && c_ready) got.push_back(c);
        if (done) done_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [31:0] v);
        wr_en = 1; wr_data = v;
        tick();
        wr_en = 0;
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic chk_got(input string name, input logic [31:0] exp[$]);
        chk({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(name, got[i], exp[i]);
    endtask

    initial begin
        // Reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            wr_en = i[0]; start = ~i[0]; wr_data = 32'hA0 + i; tick();
        end
        wr_en = 0; start = 0;
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_c", c, 32'd0);
        chk("rst_busy", busy, 1'b0);
        rst = 1; tick();

        // Basic burst
        wr(32'd1); wr(32'd2); wr(32'hFFFF_FFFF); wr(32'd4);
        got.delete(); done_pulses = 0;
        c_ready = 1; pulse_start();
        repeat (8) tick();
        chk_got("burst_seq", '{32'd1, 32'd2, 32'hFFFF_FFFF, 32'd4});
        chk("burst_sent", sent_count, 16'd4);
        chk("burst_done", done_pulses, 1);
        chk("burst_busy", busy, 1'b0);
        c_ready = 0;

        // Backpressure mid-burst
        wr(32'd1); wr(32'd2); wr(32'hFFFF_FFFF); wr(32'd4);
        got.delete(); done_pulses = 0;
        c_ready = 1; pulse_start();
        tick(); tick();
        c_ready = 0; repeat (3) tick();
        c_ready = 1; repeat (6) tick();
        chk_got("bp_seq", '{32'd1, 32'd2, 32'hFFFF_FFFF, 32'd4});
        chk("bp_sent", sent_count, 16'd4);
        chk("bp_done", done_pulses, 1);
        c_ready = 0;

        // Full and overflow, then write accepted alongside a pop while full
        for (int i = 0; i <= DEPTH; i++) wr(32'h10 + i);
        chk("ovf_full", full, 1'b1);
        chk("ovf_flag", overflow, 1'b1);
        got.delete(); done_pulses = 0;
        pulse_start();
        wr_en = 1; wr_data = 32'h99; c_ready = 1; tick();
        wr_en = 0;
        chk("ovf_full_after_swap", full, 1'b1);
        repeat (12) tick();
        chk_got("ovf_seq", '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17, 32'h99});
        chk("ovf_sticky", overflow, 1'b1);
        c_ready = 0;

        // Abort after two transfers, then resume
        wr(32'h50); wr(32'h51); wr(32'h52); wr(32'h53);
        got.delete(); done_pulses = 0;
        c_ready = 1; pulse_start();
        tick();
        stop = 1; tick(); stop = 0;
        repeat (2) tick();
        chk("abort_busy", busy, 1'b0);
        chk("abort_empty", empty, 1'b0);
        chk("abort_done", done_pulses, 0);
        chk_got("abort_seq", '{32'h50, 32'h51});
        got.delete();
        pulse_start();
        repeat (6) tick();
        chk_got("resume_seq", '{32'h52, 32'h53});
        chk("resume_sent", sent_count, 16'd2);
        chk("resume_done", done_pulses, 1);
        c_ready = 0;

        // Asynchronous reset while streaming
        wr(32'h7); wr(32'h8); wr(32'h9);
        pulse_start();
        tick();
        chk("pre_rst_valid", c_valid, 1'b1);
        rst = 0;
        #1;
        chk("async_valid", c_valid, 1'b0);
        chk("async_empty", empty, 1'b1);
        chk("async_busy", busy, 1'b0);
        chk("async_ovf", overflow, 1'b0);
        tick();
        rst = 1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
